// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data memory responder.
package dmem_pkg;

  localparam int WORD_W              = 32;
  localparam int DEFAULT_DEPTH_WORDS = 1024;
  localparam int DEFAULT_LATENCY     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous byte-laned write, combinational read sampled by the owner.
// Contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
  input  logic                           clk_i,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [WORD_W-1:0]              wr_dat,
  input  logic [3:0]                     wr_be,
  output logic [WORD_W-1:0]              rd_dat
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[idx][8*b +: 8] <= wr_dat[8*b +: 8];
      end
    end
  end

  assign rd_dat = mem[idx];

endmodule

// File: rtl/data_memory_responder.sv
// Single-outstanding memory responder: ack_o pulses LATENCY cycles after capture (DMEM_BYTE_MASK_EN: byte-masked writes).
// req_i is ignored while busy_o is high; no other backpressure.
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [3:0]        be_i,
  output logic              ack_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t            state;
  logic [3:0]        cnt;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [3:0]        be_q;

  logic              cur_we;
  logic [31:0]       cur_addr;
  logic [WORD_W-1:0] cur_wdata;
  logic [3:0]        cur_be;
  logic [3:0]        be_eff;
  logic              cur_err;
  logic              go_resp;
  logic              mem_wr;
  logic [WORD_W-1:0] mem_rd;

  // With LATENCY=1 the RESP edge is the capture edge, so use the live inputs in IDLE.
  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_be    = be_q;
    if (state == IDLE) begin
      cur_we    = we_i;
      cur_addr  = addr_i;
      cur_wdata = wdata_i;
      cur_be    = be_i;
    end
  end

`ifdef DMEM_BYTE_MASK_EN
  assign be_eff = cur_be;
`else
  // Enables are don't-care in this build: every write is a full word.
  assign be_eff = cur_be | 4'hF;
`endif

  assign cur_err = (cur_addr[1:0] != 2'b00) || (cur_addr[31:AW+2] != '0);
  assign go_resp = ((state == IDLE) && req_i && (LATENCY == 1)) ||
                   ((state == WAIT) && (cnt == 4'd1));
  assign mem_wr  = go_resp && cur_we && !cur_err;

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk_i  (clk_i),
    .wr_en  (mem_wr),
    .idx    (cur_addr[AW+1:2]),
    .wr_dat (cur_wdata),
    .wr_be  (be_eff),
    .rd_dat (mem_rd)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      busy_o  <= 1'b0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            be_q    <= be_i;
            busy_o  <= 1'b1;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase

      if (go_resp) begin
        ack_o <= 1'b1;
        err_o <= cur_err;
        if (cur_err)     rdata_o <= '0;
        else if (!cur_we) rdata_o <= mem_rd;
      end
    end
  end

endmodule
